// File: rtl/frac_div_ctrl_pkg.sv
// Shared constants, FSM state type and ratio clamp for the fractional
// feedback divider controller.
package frac_div_pkg;

    localparam int DEF_NW   = 8;
    localparam int DEF_FW   = 16;
    localparam int DEF_NMIN = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Integer ratios below the minimum are raised to it rather than rejected.
    function automatic int unsigned clamp_ratio(input int unsigned value,
                                                input int unsigned nmin);
        return (value < nmin) ? nmin : value;
    endfunction

endpackage

// File: rtl/frac_div_ctrl_if.sv
// Configuration handshake between the loop controller and the divider.
interface frac_div_ctrl_if #(
    parameter int NW = 8,
    parameter int FW = 16
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [NW-1:0] cfg_int;
    logic [FW-1:0] cfg_frac;

    modport master (
        output cfg_valid,
        output cfg_int,
        output cfg_frac,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_int,
        input  cfg_frac,
        output cfg_ready
    );
endinterface

// File: rtl/frac_div_ctrl_accum.sv
// First-order fractional accumulator: adds the fractional word once per
// division period and reports the overflow as the period's extra cycle.
module frac_accum
    import frac_div_pkg::*;
#(
    parameter int FW = DEF_FW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          update,
    input  logic [FW-1:0] frac,
    output logic          carry_next,
    output logic          carry
);

    logic [FW-1:0] acc;
    logic [FW:0]   sum;

    assign sum        = {1'b0, acc} + {1'b0, frac};
    assign carry_next = sum[FW];

    // Phase and carry advance only at a period boundary; reset is the only clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            carry <= 1'b0;
        end else if (update) begin
            acc   <= sum[FW-1:0];
            carry <= sum[FW];
        end
    end

endmodule

// File: rtl/frac_div_ctrl.sv
// Modulus controller for the PLL feedback divider. Counts prescaler clocks
// and pulses once per period of int + carry cycles, with configuration
// double-buffered and applied only at period boundaries.
module frac_div_ctrl
    import frac_div_pkg::*;
#(
    parameter int NW   = DEF_NW,
    parameter int FW   = DEF_FW,
    parameter int NMIN = DEF_NMIN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    frac_div_ctrl_if.slave       cfg,
    output logic                 div_pulse,
    output logic                 carry,
    output logic [NW:0]          cur_ratio,
    output logic                 busy
);

    localparam logic [NW:0] ONE = (NW+1)'(1);

    state_t        state, state_next;
    logic [NW:0]   cnt, cnt_next;
    logic [NW:0]   ratio_next;
    logic [NW-1:0] active_int, shadow_int;
    logic [FW-1:0] active_frac, shadow_frac;
    logic          shadow_empty;
    logic          tc;
    logic          apply_now;
    logic [NW-1:0] next_int;
    logic [FW-1:0] next_frac;
    logic          carry_next;
    logic [NW:0]   tc_ratio;
    logic [NW:0]   idle_ratio;

    // Terminal count is the pulse cycle; pending configuration lands there,
    // or on the cycle after capture when the divider is idle.
    assign tc         = (state == RUN) && (cnt == '0);
    assign apply_now  = !shadow_empty && ((state == IDLE) || tc);
    assign next_int   = apply_now ? shadow_int  : active_int;
    assign next_frac  = apply_now ? shadow_frac : active_frac;
    assign tc_ratio   = {1'b0, next_int} + {{NW{1'b0}}, carry_next};
    assign idle_ratio = apply_now ? ({1'b0, shadow_int} + {{NW{1'b0}}, carry})
                                  : cur_ratio;
    assign cfg.cfg_ready = shadow_empty;

    frac_accum #(
        .FW(FW)
    ) u_accum (
        .clk        (clk),
        .rst        (rst),
        .update     (tc),
        .frac       (next_frac),
        .carry_next (carry_next),
        .carry      (carry)
    );

    // Next state, counter reload and period ratio.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ratio_next = cur_ratio;
        case (state)
            IDLE: begin
                ratio_next = idle_ratio;
                if (en) begin
                    state_next = RUN;
                    cnt_next   = idle_ratio - ONE;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    ratio_next = tc_ratio;
                    if (en) begin
                        cnt_next = tc_ratio - ONE;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Registered FSM, counter and outputs; the pulse marks the cnt==0 cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_ratio <= (NW+1)'(NMIN);
            div_pulse <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            cur_ratio <= ratio_next;
            div_pulse <= (state_next == RUN) && (cnt_next == '0);
            busy      <= (state_next == RUN);
        end
    end

    // Shadow capture on handshake, then copy to the active set when applied.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_empty <= 1'b1;
            shadow_int   <= NW'(NMIN);
            shadow_frac  <= '0;
            active_int   <= NW'(NMIN);
            active_frac  <= '0;
        end else if (cfg.cfg_valid && shadow_empty) begin
            shadow_int   <= NW'(clamp_ratio(32'(cfg.cfg_int), NMIN));
            shadow_frac  <= cfg.cfg_frac;
            shadow_empty <= 1'b0;
        end else if (apply_now) begin
            active_int   <= shadow_int;
            active_frac  <= shadow_frac;
            shadow_empty <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frac_div_ctrl.sv
// Self-checking bench for frac_div_ctrl against a period-level reference model.
module tb_frac_div_ctrl;

    localparam int NW   = 8;
    localparam int FW   = 16;
    localparam int NMIN = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic          div_pulse, carry, busy;
    logic [NW:0]   cur_ratio;
    logic [NW+4:0] obs_vec;

    int tests = 0;
    int fails = 0;

    // Reference model: absolute cycle numbers, phase in plain integers.
    int m_now = 0, m_pulse_at = 0;
    int m_int = NMIN, m_frac = 0, m_acc = 0, m_carry = 0, m_ratio = NMIN;
    int m_sh_int = 0, m_sh_frac = 0;
    bit m_run = 0, m_pulse = 0, m_sh_full = 0;

    frac_div_ctrl_if #(.NW(NW), .FW(FW)) cif ();

    frac_div_ctrl #(.NW(NW), .FW(FW), .NMIN(NMIN)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg       (cif.slave),
        .div_pulse (div_pulse),
        .carry     (carry),
        .cur_ratio (cur_ratio),
        .busy      (busy)
    );

    assign obs_vec = {div_pulse, carry, busy, cif.cfg_ready, cur_ratio};

    always #5 clk = ~clk;

    function automatic logic [NW+4:0] exp_vec();
        return {m_pulse, m_carry[0], m_run, ~m_sh_full, (NW+1)'(m_ratio)};
    endfunction

    task automatic model_reset();
        m_run = 0; m_pulse = 0; m_sh_full = 0;
        m_int = NMIN; m_frac = 0; m_acc = 0; m_carry = 0; m_ratio = NMIN;
    endtask

    // One rising edge of the reference model using the bench-driven inputs.
    task automatic model_edge();
        bit pulse_end = m_pulse;
        bit had_sh    = m_sh_full;
        bit xfer      = cif.cfg_valid && !m_sh_full;
        int sum;
        m_now++;
        if (m_run && pulse_end) begin
            if (had_sh) begin m_int = m_sh_int; m_frac = m_sh_frac; m_sh_full = 0; end
            sum     = m_acc + m_frac;
            m_carry = sum >> FW;
            m_acc   = sum % (1 << FW);
            m_ratio = m_int + m_carry;
            if (en) m_pulse_at = m_now + m_ratio - 1;
            else    m_run = 0;
        end else if (!m_run) begin
            if (had_sh) begin
                m_int = m_sh_int; m_frac = m_sh_frac; m_sh_full = 0;
                m_ratio = m_int + m_carry;
            end
            if (en) begin m_run = 1; m_pulse_at = m_now + m_ratio - 1; end
        end
        if (xfer) begin
            m_sh_int  = (int'(cif.cfg_int) < NMIN) ? NMIN : int'(cif.cfg_int);
            m_sh_frac = int'(cif.cfg_frac);
            m_sh_full = 1;
        end
        m_pulse = m_run && (m_now == m_pulse_at);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic configure(input int ival, input int fval);
        cif.cfg_valid = 1'b1;
        cif.cfg_int   = NW'(ival);
        cif.cfg_frac  = FW'(fval);
        tick();
        cif.cfg_valid = 1'b0;
        tick();
    endtask

    task automatic stop_run();
        bit bad = 0;
        en = 1'b0;
        for (int i = 0; i < 600 && m_run; i++) begin
            tick();
            if (!bad && obs_vec !== exp_vec()) begin
                bad = 1;
                $display("[TB] FAIL stop_trace: got %h expected %h", obs_vec, exp_vec());
            end
        end
        tests++;
        if (bad || m_run) begin
            fails++;
            if (!bad) $display("[TB] FAIL stop_timeout: busy=%0b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0;
        cif.cfg_valid = 1'b0; cif.cfg_int = '0; cif.cfg_frac = '0;
        @(negedge clk); @(negedge clk);
        tests++;
        if (obs_vec !== {1'b0, 1'b0, 1'b0, 1'b1, (NW+1)'(NMIN)}) begin
            fails++;
            $display("[TB] FAIL reset_values: got %h expected %h", obs_vec,
                     {1'b0, 1'b0, 1'b0, 1'b1, (NW+1)'(NMIN)});
        end
        rst = 1'b1;
        model_reset();
        tick(); tick();
        tests++;
        if (obs_vec !== exp_vec()) begin
            fails++;
            $display("[TB] FAIL reset_idle: got %h expected %h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_integer();
        bit bad = 0;
        int pq[$];
        configure(8, 0);
        en = 1'b1;
        for (int i = 1; i <= 48; i++) begin
            tick();
            if (div_pulse) pq.push_back(i);
            if (!bad && obs_vec !== exp_vec()) begin
                bad = 1;
                $display("[TB] FAIL integer_trace: got %h expected %h", obs_vec, exp_vec());
            end
        end
        tests++;
        if (bad) fails++;
        tests++;
        if (pq.size() != 6 || pq[0] != 8 || pq[5] != 48) begin
            fails++;
            $display("[TB] FAIL integer_spacing: got %0d pulses expected 6 at multiples of 8",
                     pq.size());
        end
        stop_run();
    endtask

    task automatic test_quarter();
        bit bad = 0, got = 0;
        int cyc = 0, np = 0;
        configure(8, 16'h4000);
        en = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            if (div_pulse) got = 1;
            if (!bad && obs_vec !== exp_vec()) bad = 1;
        end
        for (int i = 0; i < 4000 && np < 400; i++) begin
            tick();
            cyc++;
            if (div_pulse) np++;
            if (!bad && obs_vec !== exp_vec()) begin
                bad = 1;
                $display("[TB] FAIL quarter_trace: got %h expected %h", obs_vec, exp_vec());
            end
        end
        tests++;
        if (bad) fails++;
        tests++;
        if (np != 400 || cyc != 3300) begin
            fails++;
            $display("[TB] FAIL quarter_average: got %0d cycles over %0d periods expected 3300 over 400",
                     cyc, np);
        end
        stop_run();
    endtask

    task automatic test_clamp_max();
        bit bad = 0;
        int pq[$];
        int maxr = 0;
        configure(2, 0);
        en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (div_pulse) pq.push_back(i);
            if (!bad && obs_vec !== exp_vec()) bad = 1;
        end
        tests++;
        if (pq.size() < 3 || pq[2] - pq[1] != 4 || pq[1] - pq[0] != 4) begin
            fails++;
            $display("[TB] FAIL clamp_ratio: got %0d pulses expected steady spacing of 4", pq.size());
        end
        stop_run();
        pq.delete();
        configure(255, 16'hFFFF);
        en = 1'b1;
        for (int i = 1; i <= 800; i++) begin
            tick();
            if (div_pulse) pq.push_back(i);
            if (int'(cur_ratio) > maxr) maxr = int'(cur_ratio);
            if (!bad && obs_vec !== exp_vec()) begin
                bad = 1;
                $display("[TB] FAIL max_trace: got %h expected %h", obs_vec, exp_vec());
            end
        end
        tests++;
        if (bad) fails++;
        tests++;
        if (maxr != 256 || pq.size() != 3 || pq[2] - pq[1] != 256) begin
            fails++;
            $display("[TB] FAIL max_ratio: got max %0d with %0d pulses expected 256 with 3",
                     maxr, pq.size());
        end
        stop_run();
    endtask

    task automatic test_midperiod();
        bit bad = 0;
        int seen = 0, off = 0;
        logic rdy8 = 1'bx, rdy9 = 1'bx;
        int pq[$];
        configure(8, 0);
        en = 1'b1;
        for (int i = 0; i < 100 && seen < 2; i++) begin
            tick();
            if (m_pulse) seen++;
            if (!bad && obs_vec !== exp_vec()) bad = 1;
        end
        for (int i = 0; i < 35; i++) begin
            cif.cfg_valid = (off == 3 || off == 4);
            cif.cfg_int   = (off == 3) ? NW'(12) : NW'(5);
            cif.cfg_frac  = '0;
            tick();
            off++;
            if (div_pulse) pq.push_back(off);
            if (off == 8) rdy8 = cif.cfg_ready;
            if (off == 9) rdy9 = cif.cfg_ready;
            if (!bad && obs_vec !== exp_vec()) begin
                bad = 1;
                $display("[TB] FAIL midperiod_trace: got %h expected %h", obs_vec, exp_vec());
            end
        end
        cif.cfg_valid = 1'b0;
        tests++;
        if (bad || seen != 2) fails++;
        tests++;
        if (pq.size() != 3 || pq[0] != 8 || pq[1] != 20 || pq[2] != 32) begin
            fails++;
            $display("[TB] FAIL midperiod_pulses: got %0d pulses expected offsets 8,20,32", pq.size());
        end
        tests++;
        if (rdy8 !== 1'b0 || rdy9 !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midperiod_ready: got %b%b expected 01", rdy8, rdy9);
        end
    endtask

    task automatic test_back_to_back();
        bit bad = 0, got = 0;
        int off = 0;
        int pq[$];
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (m_pulse) got = 1;
            if (!bad && obs_vec !== exp_vec()) bad = 1;
        end
        cif.cfg_valid = 1'b1;
        cif.cfg_int   = NW'(6);
        cif.cfg_frac  = '0;
        for (int i = 0; i < 30; i++) begin
            tick();
            cif.cfg_valid = 1'b0;
            off++;
            if (off == 20) en = 1'b0;
            if (div_pulse) pq.push_back(off);
            if (!bad && obs_vec !== exp_vec()) begin
                bad = 1;
                $display("[TB] FAIL b2b_trace: got %h expected %h", obs_vec, exp_vec());
            end
        end
        tests++;
        if (bad || !got) fails++;
        tests++;
        if (pq.size() != 3 || pq[0] != 12 || pq[1] != 18 || pq[2] != 24) begin
            fails++;
            $display("[TB] FAIL b2b_pulses: got %0d pulses expected offsets 12,18,24", pq.size());
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL b2b_stop_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_random();
        bit bad = 0;
        for (int i = 0; i < 1500; i++) begin
            en = en ? ($urandom_range(0, 99) >= 2) : ($urandom_range(0, 99) < 20);
            cif.cfg_valid = ($urandom_range(0, 29) == 0);
            cif.cfg_int   = ($urandom_range(0, 9) == 0) ? NW'($urandom_range(250, 255))
                                                       : NW'($urandom_range(0, 20));
            cif.cfg_frac  = FW'($urandom);
            tick();
            if (!bad && obs_vec !== exp_vec()) begin
                bad = 1;
                $display("[TB] FAIL random_trace: got %h expected %h at cycle %0d",
                         obs_vec, exp_vec(), i);
            end
        end
        cif.cfg_valid = 1'b0;
        tests++;
        if (bad) fails++;
    endtask

    task automatic test_async_reset();
        bit bad = 0, quiet = 1;
        int first = -1;
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bad && obs_vec !== exp_vec()) bad = 1;
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if (obs_vec !== {1'b0, 1'b0, 1'b0, 1'b1, (NW+1)'(NMIN)}) begin
            fails++;
            $display("[TB] FAIL async_reset_values: got %h expected %h", obs_vec,
                     {1'b0, 1'b0, 1'b0, 1'b1, (NW+1)'(NMIN)});
        end
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (div_pulse !== 1'b0) quiet = 0;
        end
        tests++;
        if (!quiet) begin
            fails++;
            $display("[TB] FAIL async_reset_quiet: got pulse expected none");
        end
        rst = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (div_pulse && first < 0) first = i;
            if (!bad && obs_vec !== exp_vec()) begin
                bad = 1;
                $display("[TB] FAIL restart_trace: got %h expected %h", obs_vec, exp_vec());
            end
        end
        tests++;
        if (bad) fails++;
        tests++;
        if (first != NMIN || cur_ratio !== (NW+1)'(NMIN)) begin
            fails++;
            $display("[TB] FAIL restart_ratio: got first pulse %0d ratio %0d expected %0d",
                     first, cur_ratio, NMIN);
        end
    endtask

    initial begin
        test_reset();
        test_integer();
        test_quarter();
        test_clamp_max();
        test_midperiod();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frac_div_ctrl.md
Name: frac_div_ctrl

Overview:
Modulus controller for the PLL feedback divider chain. It counts VCO-domain clock cycles and emits one feedback pulse per division period. The period is int + carry, where carry comes from a first-order fractional accumulator, so the average division ratio is int + frac/2^FW. It sits between the fixed prescaler stage (divide-by-4) and the PFD. Configuration is double-buffered and applied only at period boundaries, so ratio changes are glitch-free.

Parameters:
NW, 8, integer divide word width
FW, 16, fractional word width
NMIN, 4, minimum legal integer ratio; smaller cfg_int values are clamped

Ports:
clk  in  1  divider input clock (prescaler output)
rst  in  1  reset; one clock, asynchronous, active-low
en  in  1  run enable
cfg_valid  in  1  new configuration offered
cfg_ready  out  1  shadow register free to accept a configuration
cfg_int  in  NW  integer ratio
cfg_frac  in  FW  fractional word
div_pulse  out  1  one-cycle feedback pulse at the last cycle of each period
carry  out  1  accumulator carry used for the current period
cur_ratio  out  NW+1  ratio of the current period (int+carry)
busy  out  1  high in RUN state

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, acc=0, carry=0, active int=NMIN, active frac=0, shadow empty.
- Output reset values: cfg_ready=1, div_pulse=0, busy=0, cur_ratio=NMIN.
- All outputs are registered.
- States are IDLE and RUN.
- IDLE -> RUN: en sampled high. cnt loads cur_ratio-1 on that edge; the first div_pulse occurs cur_ratio cycles after en is sampled.
- RUN -> IDLE: only at terminal count (cnt==0, div_pulse asserted) with en low. A period in progress always completes.
- In RUN, cnt decrements by 1 each cycle. At cnt==0:
  - div_pulse=1 for exactly one cycle.
  - {c,acc} <= acc + active_frac, computed as an FW+1-bit sum.
  - carry <= c.
  - cur_ratio <= active_int + c.
  - cnt <= active_int + c - 1, giving back-to-back periods with no dead cycle.
- Counter width is NW+1. Max ratio 2^NW is legal: 255 + carry = 256.
- Config handshake: a transfer occurs on cfg_valid && cfg_ready.
  - The transfer writes the shadow register; cfg_int < NMIN is stored as NMIN.
  - cfg_ready then drops to 0 and stays low until the shadow is applied.
- Config apply:
  - In IDLE, the shadow is copied to active on the cycle after capture, and cfg_ready returns to 1.
  - In RUN, the copy happens at the next terminal count. The accumulator update at that boundary uses the new frac, and cur_ratio uses the new int.
  - A transfer in the same cycle as a terminal count is not applied at that boundary. It applies at the following boundary.
- acc is never cleared by a config change; it is cleared only by reset.
- With frac=0, carry is permanently 0 and the ratio is exactly int.
- en toggling while in IDLE has no effect on acc.

Decomposition:
- Package frac_div_pkg holds:
  - default NW, FW, NMIN constants;
  - state enum {IDLE, RUN};
  - a clamp function for the integer ratio.
- One natural sub-module: frac_accum. It holds the FW-bit register, the adder, and the carry output, with an update strobe driven by terminal count.
- The counter, FSM and shadow logic stay in the top module.

Test Plan:
- Integer division: rst released, cfg int=8 frac=0, en=1 -> div_pulse spacing 8 clk, carry always 0, cur_ratio=8.
- Quarter fraction: int=8, frac=0x4000 -> period sequence 8,8,8,8,9,8,8,8,9,... Average over 400 periods is 8.25 (±1/400).
- Clamp and maximum: cfg_int=2 -> ratio 4. Then int=255 with frac=0xFFFF -> periods mostly 256, cur_ratio=256, no counter wrap.
- Mid-period reconfiguration: change int 8->12 three cycles into a period -> current period stays 8, next is 12. cfg_ready stays low until that boundary. A second cfg_valid while not ready is ignored.
- Simultaneous events: transfer on a terminal-count cycle -> old ratio is kept for the next period, new ratio applies one period later. en dropped mid-period -> period completes with a pulse, then IDLE and busy=0.
- Async reset in RUN: assert rst mid-count -> all outputs are at their reset values immediately, with no further div_pulse. After release, a fresh start with int=NMIN and acc=0.
